// File: rtl/operand_hazard_unit.sv
// Operand fetch for the 5-stage pipeline: register-file addressing, EX/MEM forwarding
// and load-use stall detection against an internal shadow of the EX and MEM stages.
module operand_hazard_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  id_valid,
    input  logic [ADDR_WIDTH-1:0] id_rs1,
    input  logic [ADDR_WIDTH-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [ADDR_WIDTH-1:0] id_rd,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  id_ready,
    output logic [ADDR_WIDTH-1:0] rf_ra0,
    output logic [ADDR_WIDTH-1:0] rf_ra1,
    input  logic [DATA_WIDTH-1:0] rf_rd0,
    input  logic [DATA_WIDTH-1:0] rf_rd1,
    input  logic [DATA_WIDTH-1:0] ex_result,
    input  logic [DATA_WIDTH-1:0] mem_result,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic                  op_valid,
    output logic [15:0]           stall_cnt
);

    logic                  ex_valid, ex_we, ex_load;
    logic [ADDR_WIDTH-1:0] ex_rd;
    logic                  mem_valid, mem_we, mem_load;
    logic [ADDR_WIDTH-1:0] mem_rd;

    logic ex_wr_rs1, ex_wr_rs2, mem_wr_rs1, mem_wr_rs2;
    logic hazard;

    assign rf_ra0 = id_rs1;
    assign rf_ra1 = id_rs2;

    // x0 is never forwarded, so a zero source never matches a slot
    assign ex_wr_rs1  = ex_valid  & ex_we  & (ex_rd  == id_rs1) & (id_rs1 != '0);
    assign ex_wr_rs2  = ex_valid  & ex_we  & (ex_rd  == id_rs2) & (id_rs2 != '0);
    assign mem_wr_rs1 = mem_valid & mem_we & (mem_rd == id_rs1) & (id_rs1 != '0);
    assign mem_wr_rs2 = mem_valid & mem_we & (mem_rd == id_rs2) & (id_rs2 != '0);

    assign hazard   = id_valid & ex_load &
                      ((id_rs1_used & ex_wr_rs1) | (id_rs2_used & ex_wr_rs2));
    assign id_ready = !hazard && !flush;
    assign op_valid = id_valid && id_ready;

    always_comb begin
        op_a = rf_rd0;
        if (ex_wr_rs1 && !ex_load)
            op_a = ex_result;
        else if (mem_wr_rs1)
            op_a = mem_result;

        op_b = rf_rd1;
        if (ex_wr_rs2 && !ex_load)
            op_b = ex_result;
        else if (mem_wr_rs2)
            op_b = mem_result;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid  <= 1'b0;
            ex_rd     <= '0;
            ex_we     <= 1'b0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_rd    <= '0;
            mem_we    <= 1'b0;
            mem_load  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            mem_we    <= ex_we;
            mem_load  <= ex_load;
            if (op_valid) begin
                ex_valid <= 1'b1;
                ex_rd    <= id_rd;
                ex_we    <= id_we;
                ex_load  <= id_is_load;
            end else begin
                ex_valid <= 1'b0;
                ex_rd    <= '0;
                ex_we    <= 1'b0;
                ex_load  <= 1'b0;
            end
            if (hazard && !flush && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_operand_hazard_unit.sv
// Directed bench for operand_hazard_unit: forwarding priority, load-use stalls,
// flush interaction, asynchronous reset and stall counter saturation.
module tb_operand_hazard_unit;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_rs1_used, id_rs2_used, id_we, id_is_load, flush;
    logic          id_ready, op_valid;
    logic [AW-1:0] rf_ra0, rf_ra1;
    logic [DW-1:0] rf_rd0, rf_rd1, ex_result, mem_result, op_a, op_b;
    logic [15:0]   stall_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_stall = 0;

    operand_hazard_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .flush(flush),
        .id_ready(id_ready), .rf_ra0(rf_ra0), .rf_ra1(rf_ra1),
        .rf_rd0(rf_rd0), .rf_rd1(rf_rd1), .ex_result(ex_result), .mem_result(mem_result),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_rd = '0; id_we = 1'b0; id_is_load = 1'b0; flush = 1'b0;
        rf_rd0 = '0; rf_rd1 = '0; ex_result = '0; mem_result = '0;
    endtask

    task automatic producer(input logic [AW-1:0] rd, input logic is_load);
        idle();
        id_valid = 1'b1; id_rd = rd; id_we = 1'b1; id_is_load = is_load;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle();
        id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1; rf_rd0 = 32'h11;
        #3;
        checks++;
        if (id_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", id_ready); end
        checks++;
        if (op_a !== 32'h11) begin failures++; $display("FAIL reset_op_a got=%h exp=00000011", op_a); end
        checks++;
        if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++;
        if (rf_ra0 !== 5'd3) begin failures++; $display("FAIL reset_rf_ra0 got=%0d exp=3", rf_ra0); end
        tick();
        idle();
        #1 rstn = 1'b1;
        exp_stall = 0;
    endtask

    task automatic test_alu_forward();
        tick();
        producer(5'd5, 1'b0);
        #1;
        checks++;
        if (op_valid !== 1'b1) begin failures++; $display("FAIL alu_issue got=%b exp=1", op_valid); end
        tick();
        idle();
        id_valid = 1'b1; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        rf_rd0 = 32'hDEAD; ex_result = 32'hAAAA0001; mem_result = 32'h77;
        #1;
        checks++;
        if (op_a !== 32'hAAAA0001) begin failures++; $display("FAIL alu_fwd_ex got=%h exp=aaaa0001", op_a); end
        checks++;
        if (id_ready !== 1'b1) begin failures++; $display("FAIL alu_no_stall got=%b exp=1", id_ready); end
        tick();
        idle();
        id_valid = 1'b1; id_rs2 = 5'd5; id_rs2_used = 1'b1;
        rf_rd1 = 32'hBEEF; ex_result = 32'h55; mem_result = 32'hAAAA0001;
        #1;
        checks++;
        if (op_b !== 32'hAAAA0001) begin failures++; $display("FAIL alu_fwd_mem got=%h exp=aaaa0001", op_b); end
        checks++;
        if (rf_ra1 !== 5'd5) begin failures++; $display("FAIL rf_ra1 got=%0d exp=5", rf_ra1); end
    endtask

    task automatic test_load_use();
        tick();
        producer(5'd7, 1'b1);
        tick();
        idle();
        id_valid = 1'b1; id_rs1 = 5'd7; id_rs1_used = 1'b1;
        ex_result = 32'hBAD; mem_result = 32'hBAD0; rf_rd0 = 32'hBAD1;
        #1;
        checks++;
        if (id_ready !== 1'b0) begin failures++; $display("FAIL load_use_stall got=%b exp=0", id_ready); end
        checks++;
        if (op_valid !== 1'b0) begin failures++; $display("FAIL load_use_op_valid got=%b exp=0", op_valid); end
        tick();
        exp_stall++;
        mem_result = 32'h12345678;
        #1;
        checks++;
        if (id_ready !== 1'b1) begin failures++; $display("FAIL load_use_release got=%b exp=1", id_ready); end
        checks++;
        if (op_a !== 32'h12345678) begin failures++; $display("FAIL load_use_op_a got=%h exp=12345678", op_a); end
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
        // hazard through rs2
        tick();
        producer(5'd6, 1'b1);
        tick();
        idle();
        id_valid = 1'b1; id_rs2 = 5'd6; id_rs2_used = 1'b1;
        #1;
        checks++;
        if (id_ready !== 1'b0) begin failures++; $display("FAIL load_use_rs2 got=%b exp=0", id_ready); end
        tick();
        exp_stall++;
        mem_result = 32'hCAFE0006;
        #1;
        checks++;
        if (op_b !== 32'hCAFE0006) begin failures++; $display("FAIL load_use_rs2_op_b got=%h exp=cafe0006", op_b); end
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL load_use_rs2_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_x0_unused();
        tick();
        producer(5'd0, 1'b0);
        tick();
        idle();
        id_valid = 1'b1; id_rs1 = 5'd0; id_rs1_used = 1'b1;
        rf_rd0 = 32'h0; ex_result = 32'hFFFF_FFFF; mem_result = 32'hEEEE_EEEE;
        #1;
        checks++;
        if (op_a !== 32'h0) begin failures++; $display("FAIL x0_op_a got=%h exp=00000000", op_a); end
        tick();
        producer(5'd0, 1'b1);
        tick();
        idle();
        id_valid = 1'b1; id_rs1 = 5'd0; id_rs1_used = 1'b1;
        #1;
        checks++;
        if (id_ready !== 1'b1) begin failures++; $display("FAIL x0_load_no_stall got=%b exp=1", id_ready); end
        tick();
        producer(5'd4, 1'b1);
        tick();
        idle();
        id_valid = 1'b1; id_rs1 = 5'd1; id_rs1_used = 1'b1; id_rs2 = 5'd4; id_rs2_used = 1'b0;
        #1;
        checks++;
        if (id_ready !== 1'b1) begin failures++; $display("FAIL unused_no_stall got=%b exp=1", id_ready); end
    endtask

    task automatic test_priority();
        tick();
        producer(5'd9, 1'b0);
        tick();
        producer(5'd9, 1'b0);
        tick();
        idle();
        id_valid = 1'b1; id_rs1 = 5'd9; id_rs1_used = 1'b1;
        mem_result = 32'h1; ex_result = 32'h2; rf_rd0 = 32'h3;
        #1;
        checks++;
        if (op_a !== 32'h2) begin failures++; $display("FAIL prio_ex_wins got=%h exp=00000002", op_a); end
        // load in EX over ALU in MEM, same rd: must stall
        tick();
        producer(5'd9, 1'b0);
        tick();
        producer(5'd9, 1'b1);
        tick();
        idle();
        id_valid = 1'b1; id_rs1 = 5'd9; id_rs1_used = 1'b1;
        mem_result = 32'h1; ex_result = 32'h2;
        #1;
        checks++;
        if (id_ready !== 1'b0) begin failures++; $display("FAIL prio_load_stall got=%b exp=0", id_ready); end
        tick();
        exp_stall++;
        mem_result = 32'h44;
        #1;
        checks++;
        if (op_a !== 32'h44) begin failures++; $display("FAIL prio_load_mem got=%h exp=00000044", op_a); end
    endtask

    task automatic test_flush();
        tick();
        producer(5'd2, 1'b1);
        tick();
        idle();
        id_valid = 1'b1; id_rs1 = 5'd2; id_rs1_used = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (op_valid !== 1'b0) begin failures++; $display("FAIL flush_op_valid got=%b exp=0", op_valid); end
        tick();
        flush = 1'b0;
        mem_result = 32'h2222;
        #1;
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL flush_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
        checks++;
        if (id_ready !== 1'b1) begin failures++; $display("FAIL flush_bubble got=%b exp=1", id_ready); end
        checks++;
        if (op_a !== 32'h2222) begin failures++; $display("FAIL flush_op_a got=%h exp=00002222", op_a); end
        flush = 1'b1;
        #1;
        checks++;
        if (id_ready !== 1'b0) begin failures++; $display("FAIL flush_only got=%b exp=0", id_ready); end
    endtask

    task automatic test_reset_mid_stall();
        tick();
        producer(5'd3, 1'b1);
        tick();
        idle();
        id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
        #1;
        checks++;
        if (id_ready !== 1'b0) begin failures++; $display("FAIL midreset_stall got=%b exp=0", id_ready); end
        #1 rstn = 1'b0;
        #1;
        exp_stall = 0;
        checks++;
        if (id_ready !== 1'b1) begin failures++; $display("FAIL midreset_release got=%b exp=1", id_ready); end
        checks++;
        if (stall_cnt !== 16'd0) begin failures++; $display("FAIL midreset_cnt got=%0d exp=0", stall_cnt); end
        #1 rstn = 1'b1;
        idle();
    endtask

    task automatic test_saturation();
        tick();
        idle();
        force dut.ex_valid = 1'b1;
        force dut.ex_rd    = 5'd7;
        force dut.ex_we    = 1'b1;
        force dut.ex_load  = 1'b1;
        id_valid = 1'b1; id_rs1 = 5'd7; id_rs1_used = 1'b1;
        #1;
        checks++;
        if (id_ready !== 1'b0) begin failures++; $display("FAIL sat_hazard got=%b exp=0", id_ready); end
        for (int i = 0; i < 16'hFFFE; i++) tick();
        checks++;
        if (stall_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_fffe got=%h exp=fffe", stall_cnt); end
        tick();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_ffff got=%h exp=ffff", stall_cnt); end
        tick();
        tick();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
        release dut.ex_valid;
        release dut.ex_rd;
        release dut.ex_we;
        release dut.ex_load;
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_x0_unused();
        test_priority();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
